// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;
    localparam int unsigned TIME_W = 64;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;

    // Bit positions shared by mip/mie and by mstatus
    localparam int unsigned MSIP_BIT = 3;
    localparam int unsigned MTIP_BIT = 7;
    localparam int unsigned MEIP_BIT = 11;
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam logic [CODE_W-1:0] CODE_MSI = 4'd3;
    localparam logic [CODE_W-1:0] CODE_MTI = 4'd7;
    localparam logic [CODE_W-1:0] CODE_MEI = 4'd11;

    localparam logic [XLEN-1:0] CAUSE_ECALL = 32'h0000_000b;
    localparam logic [XLEN-1:0] MIE_MASK    = 32'h0000_0888;

    typedef struct packed {
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] cause;
    } trap_info_t;

    function automatic logic [XLEN-1:0] irq_cause(input logic [CODE_W-1:0] code);
        return {1'b1, 27'b0, code};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-point handshake between the pipeline and the trap sequencer.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            ecall;
    logic            mret;
    logic            drained;
    logic            kill;
    logic            flush;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_we;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] trap_cause;

    modport master (
        output commit_valid, commit_pc, ecall, mret, drained,
        input  kill, flush, redirect, redirect_pc, trap_we, trap_epc, trap_cause
    );

    modport slave (
        input  commit_valid, commit_pc, ecall, mret, drained,
        output kill, flush, redirect, redirect_pc, trap_we, trap_epc, trap_cause
    );

endinterface

// File: rtl/trap_ctrl_mtimecmp_unit.sv
// 64-bit mtimecmp register with split-word MMIO write and registered timer pending.
module trap_ctrl_mtimecmp_unit
    import trap_ctrl_pkg::*;
#(
    parameter logic [TIME_W-1:0] TIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] cycle,
    input  logic              cmp_we,
    input  logic              cmp_hi,
    input  logic [XLEN-1:0]   cmp_wdata,
    output logic              mtip
);

    logic [TIME_W-1:0] cmp_q, cmp_d;
    logic              mtip_q, mtip_d;

    always_comb begin
        cmp_d  = cmp_q;
        mtip_d = (cycle >= cmp_q);
        if (cmp_we) begin
            if (cmp_hi) cmp_d[63:32] = cmp_wdata;
            else        cmp_d[31:0]  = cmp_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q  <= TIMECMP_RST;
            mtip_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            mtip_q <= mtip_d;
        end
    end

    assign mtip = mtip_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates ECALL/MRET/interrupts at commit,
// flushes the pipeline and redirects the PC.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [TIME_W-1:0] TIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic [TIME_W-1:0] cycle,
    input  logic              meip,
    input  logic              msip,
    input  logic [XLEN-1:0]   mtvec,
    input  logic [XLEN-1:0]   mepc,
    input  logic              csr_we,
    input  logic [CSR_AW-1:0] csr_addr,
    input  logic [XLEN-1:0]   csr_wdata,
    output logic [XLEN-1:0]   csr_rdata,
    input  logic              cmp_we,
    input  logic              cmp_hi,
    input  logic [XLEN-1:0]   cmp_wdata,
    trap_ctrl_if.slave        pif
);

    state_e          state_q, state_d;
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic            is_ret_q, is_ret_d;
    logic [XLEN-1:0] ret_pc_q, ret_pc_d;
    logic [XLEN-1:0] csr_rdata_q, csr_rdata_d;

    logic            mtip;
    logic [XLEN-1:0] mip_c;
    logic [XLEN-1:0] pend_c;
    logic            irq_c;
    logic [CODE_W-1:0] irq_code_c;
    logic            can_accept_c;
    logic            take_trap_c;
    logic            take_ret_c;
    trap_info_t      trap_c;
    logic [XLEN-1:0] mstatus_rd_c;
    logic            unused_mtvec_lo;

    assign unused_mtvec_lo = ^mtvec[1:0];

    trap_ctrl_mtimecmp_unit #(
        .TIMECMP_RST (TIMECMP_RST)
    ) u_mtimecmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cycle     (cycle),
        .cmp_we    (cmp_we),
        .cmp_hi    (cmp_hi),
        .cmp_wdata (cmp_wdata),
        .mtip      (mtip)
    );

    // Pending/enabled interrupt selection and acceptance priority
    always_comb begin
        mip_c           = '0;
        mip_c[MEIP_BIT] = meip;
        mip_c[MTIP_BIT] = mtip;
        mip_c[MSIP_BIT] = msip;
        pend_c          = mip_c & mie_q;
        irq_c           = mstatus_mie_q & (|pend_c);

        if (pend_c[MEIP_BIT])      irq_code_c = CODE_MEI;
        else if (pend_c[MSIP_BIT]) irq_code_c = CODE_MSI;
        else                       irq_code_c = CODE_MTI;

        can_accept_c = (state_q == ST_IDLE) && pif.commit_valid && !halt;
        take_trap_c  = can_accept_c && (pif.ecall || (!pif.mret && irq_c));
        take_ret_c   = can_accept_c && !pif.ecall && pif.mret;

        trap_c.epc   = pif.commit_pc;
        trap_c.cause = pif.ecall ? CAUSE_ECALL : irq_cause(irq_code_c);

        mstatus_rd_c = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (take_trap_c || take_ret_c) state_d = ST_FLUSH;
            ST_FLUSH:    if (pif.drained)               state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; trap target reads mtvec live so the CSR update is visible
    always_comb begin
        pif.kill        = take_trap_c;
        pif.trap_we     = take_trap_c;
        pif.trap_epc    = take_trap_c ? trap_c.epc   : '0;
        pif.trap_cause  = take_trap_c ? trap_c.cause : '0;
        pif.flush       = (state_q == ST_FLUSH);
        pif.redirect    = (state_q == ST_REDIRECT);
        pif.redirect_pc = '0;
        if (state_q == ST_REDIRECT)
            pif.redirect_pc = is_ret_q ? ret_pc_q : {mtvec[31:2], 2'b00};
    end

    // CSR write/read; sequencer update of MIE/MPIE overrides a same-cycle write
    always_comb begin
        mstatus_mie_d = mstatus_mie_q;
        mpie_d        = mpie_q;
        mie_d         = mie_q;
        is_ret_d      = is_ret_q;
        ret_pc_d      = ret_pc_q;
        csr_rdata_d   = '0;

        if (csr_we) begin
            unique case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d = csr_wdata[MIE_BIT];
                    mpie_d        = csr_wdata[MPIE_BIT];
                end
                CSR_MIE: mie_d = csr_wdata & MIE_MASK;
                default: ;
            endcase
        end

        if (take_trap_c) begin
            mpie_d        = mstatus_mie_q;
            mstatus_mie_d = 1'b0;
            is_ret_d      = 1'b0;
        end else if (take_ret_c) begin
            mstatus_mie_d = mpie_q;
            mpie_d        = 1'b1;
            is_ret_d      = 1'b1;
            ret_pc_d      = mepc;
        end

        unique case (csr_addr)
            CSR_MSTATUS: csr_rdata_d = mstatus_rd_c;
            CSR_MIE:     csr_rdata_d = mie_q;
            CSR_MIP:     csr_rdata_d = mip_c;
            default:     csr_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q <= 1'b0;
            mpie_q        <= 1'b0;
            mie_q         <= '0;
            is_ret_q      <= 1'b0;
            ret_pc_q      <= '0;
            csr_rdata_q   <= '0;
        end else begin
            mstatus_mie_q <= mstatus_mie_d;
            mpie_q        <= mpie_d;
            mie_q         <= mie_d;
            is_ret_q      <= is_ret_d;
            ret_pc_q      <= ret_pc_d;
            csr_rdata_q   <= csr_rdata_d;
        end
    end

    assign csr_rdata = csr_rdata_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed trap/MRET/interrupt sequences.
module tb_trap_ctrl;

    typedef struct {
        logic [31:0] epc;
        logic [31:0] cause;
    } trap_exp_t;

    typedef struct {
        logic [31:0] pc;
        int          nflush;
    } redir_exp_t;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic [63:0] cyc;
    logic        meip, msip;
    logic [31:0] mtvec, mepc;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        cmp_we, cmp_hi;
    logic [31:0] cmp_wdata;

    trap_ctrl_if pif ();

    trap_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .halt      (halt),
        .cycle     (cyc),
        .meip      (meip),
        .msip      (msip),
        .mtvec     (mtvec),
        .mepc      (mepc),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .cmp_we    (cmp_we),
        .cmp_hi    (cmp_hi),
        .cmp_wdata (cmp_wdata),
        .pif       (pif)
    );

    trap_exp_t  trap_q[$];
    redir_exp_t redir_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int fcnt   = 0;
    int redir_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 64'd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected trap/redirect events whenever the DUT presents one
    always @(negedge clk) begin : monitor
        trap_exp_t  t;
        redir_exp_t r;
        if (!rst_n) begin
            fcnt = 0;
        end else begin
            if (pif.flush) fcnt++;
            if (pif.kill) chk("kill_implies_trap_we", 64'(pif.trap_we), 64'd1);
            if (pif.trap_we) begin
                if (trap_q.size() == 0) begin
                    chk("unexpected_trap_we", 64'd1, 64'd0);
                end else begin
                    t = trap_q.pop_front();
                    chk("trap_epc", 64'(pif.trap_epc), 64'(t.epc));
                    chk("trap_cause", 64'(pif.trap_cause), 64'(t.cause));
                    chk("kill_with_trap", 64'(pif.kill), 64'd1);
                end
            end
            if (pif.redirect) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect", 64'd1, 64'd0);
                end else begin
                    r = redir_q.pop_front();
                    chk("redirect_pc", 64'(pif.redirect_pc), 64'(r.pc));
                    chk("flush_cycles", 64'(fcnt), 64'(r.nflush));
                end
                fcnt = 0;
                redir_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        tick();
        chk(nm, 64'(csr_rdata), 64'(exp));
    endtask

    task automatic cmp_write(input logic hi, input logic [31:0] d);
        cmp_we = 1'b1; cmp_hi = hi; cmp_wdata = d;
        tick();
        cmp_we = 1'b0;
    endtask

    // Present one instruction at commit for a single cycle
    task automatic commit(input logic [31:0] pc, input logic ec, input logic mr);
        pif.commit_valid = 1'b1; pif.commit_pc = pc; pif.ecall = ec; pif.mret = mr;
        tick();
        pif.commit_valid = 1'b0; pif.ecall = 1'b0; pif.mret = 1'b0;
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause);
        trap_exp_t t;
        t.epc = epc; t.cause = cause;
        trap_q.push_back(t);
    endtask

    task automatic push_redir(input logic [31:0] pc, input int nf);
        redir_exp_t r;
        r.pc = pc; r.nflush = nf;
        redir_q.push_back(r);
    endtask

    task automatic wait_redirect(input string nm, input int target);
        int n;
        n = 0;
        while (redir_seen < target && n < 40) begin
            tick();
            n++;
        end
        if (redir_seen < target) chk(nm, 64'(redir_seen), 64'(target));
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0; meip = 1'b0; msip = 1'b0;
        mtvec = 32'h201; mepc = 32'h0;
        csr_we = 1'b0; csr_addr = 12'h300; csr_wdata = '0;
        cmp_we = 1'b0; cmp_hi = 1'b0; cmp_wdata = '0;
        pif.commit_valid = 1'b0; pif.commit_pc = '0; pif.ecall = 1'b0;
        pif.mret = 1'b0; pif.drained = 1'b1;
        #12;
        chk("rst_csr_rdata", 64'(csr_rdata), 64'd0);
        chk("rst_flush", 64'(pif.flush), 64'd0);
        chk("rst_redirect", 64'(pif.redirect), 64'd0);
        rst_n = 1'b1;
        tick();
        csr_read("rst_mstatus", 12'h300, 32'h1800);
        csr_read("rst_mie", 12'h304, 32'h0);

        // ECALL with a same-cycle mstatus write that must lose to the trap update
        csr_write(12'h300, 32'h8);
        push_trap(32'h100, 32'hb);
        push_redir(32'h200, 1);
        csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h88;
        commit(32'h100, 1'b1, 1'b0);
        csr_we = 1'b0;
        wait_redirect("ecall_redirect_timeout", 1);
        csr_read("ecall_mstatus", 12'h300, 32'h1880);

        // Timer: program mtimecmp=10 split-word, mip reads mtip; 0x344 writes ignored
        cmp_write(1'b0, 32'd10);
        cmp_write(1'b1, 32'd0);
        tick();
        csr_write(12'h344, 32'hFFFF_FFFF);
        csr_read("mip_timer", 12'h344, 32'h80);
        csr_write(12'h304, 32'h80);
        commit(32'h300, 1'b0, 1'b0);
        csr_write(12'h300, 32'h8);
        push_trap(32'h304, 32'h8000_0007);
        push_redir(32'h200, 1);
        commit(32'h304, 1'b0, 1'b0);
        wait_redirect("mti_redirect_timeout", 2);

        // All sources pending: external wins, then software after MRET
        csr_write(12'h304, 32'hFFFF_FFFF);
        csr_read("mie_mask", 12'h304, 32'h888);
        meip = 1'b1; msip = 1'b1;
        csr_write(12'h300, 32'h8);
        push_trap(32'h500, 32'h8000_000b);
        push_redir(32'h200, 1);
        commit(32'h500, 1'b0, 1'b0);
        wait_redirect("mei_redirect_timeout", 3);
        mepc = 32'h600;
        push_redir(32'h600, 1);
        pif.commit_valid = 1'b1; pif.commit_pc = 32'h204; pif.mret = 1'b1;
        @(negedge clk);
        chk("mret_kill", 64'(pif.kill), 64'd0);
        tick();
        pif.commit_valid = 1'b0; pif.mret = 1'b0;
        meip = 1'b0;
        wait_redirect("mret1_redirect_timeout", 4);
        csr_read("mret1_mstatus", 12'h300, 32'h1888);
        push_trap(32'h600, 32'h8000_0003);
        push_redir(32'h200, 1);
        commit(32'h600, 1'b0, 1'b0);
        wait_redirect("msi_redirect_timeout", 5);

        // MRET with a slow drain: five flush cycles, one redirect
        msip = 1'b0;
        mepc = 32'h400;
        push_redir(32'h400, 5);
        pif.drained = 1'b0;
        commit(32'h208, 1'b0, 1'b1);
        repeat (4) tick();
        pif.drained = 1'b1;
        wait_redirect("mret2_redirect_timeout", 6);
        csr_read("mret2_mstatus", 12'h300, 32'h1888);

        // Pending timer irq blocked by halt and by no commit
        halt = 1'b1;
        pif.commit_valid = 1'b1; pif.commit_pc = 32'h700;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_kill", 64'(pif.kill), 64'd0);
            chk("halt_trap_we", 64'(pif.trap_we), 64'd0);
            tick();
        end
        halt = 1'b0; pif.commit_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("nocommit_kill", 64'(pif.kill), 64'd0);
            tick();
        end
        push_trap(32'h700, 32'h8000_0007);
        push_redir(32'h200, 1);
        pif.commit_valid = 1'b1;
        @(negedge clk);
        chk("gated_accept_kill", 64'(pif.kill), 64'd1);
        tick();
        pif.commit_valid = 1'b0;
        wait_redirect("gated_redirect_timeout", 7);

        // Reset in FLUSH abandons the trap
        pif.drained = 1'b0;
        push_trap(32'h800, 32'hb);
        commit(32'h800, 1'b1, 1'b0);
        #2;
        chk("pre_reset_flush", 64'(pif.flush), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_flush", 64'(pif.flush), 64'd0);
        chk("reset_redirect", 64'(pif.redirect), 64'd0);
        chk("reset_kill", 64'(pif.kill), 64'd0);
        chk("reset_csr_rdata", 64'(csr_rdata), 64'd0);
        tick();
        pif.drained = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("reset_no_redirect", 64'(redir_seen), 64'd7);
        csr_read("reset_mstatus", 12'h300, 32'h1800);
        csr_read("reset_mie", 12'h304, 32'h0);

        tick();
        chk("trap_queue_empty", 64'(trap_q.size()), 64'd0);
        chk("redir_queue_empty", 64'(redir_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
